// File: rtl/qrd_row_feeder.sv
// qrd_row_feeder: transmit side of the QRD row-input interface.
// Accepts one augmented matrix [H|y] (4 rows x 5 complex samples, row-major,
// y in column 4) over a valid/ready stream, buffers it, then replays it on
// row_in_1..4 using the fixed staggered schedule the QRD core expects.
// Build option: define QRD_FEED_PINGPONG_EN for a second buffer bank so the
// next matrix can load while the current one is waiting or playing.
module qrd_row_feeder #(
  parameter int unsigned IN_width = 14,
  parameter int unsigned ROW3_T0  = 31,
  parameter int unsigned ROW4_T0  = 61,
  parameter int unsigned ROW2_F_T = 2,
  parameter int unsigned ROW3_F_T = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_width-1:0] s_data_r,
  input  logic [IN_width-1:0] s_data_i,
  input  logic                s_last,
  input  logic                qrd_in_ready,
  output logic [IN_width-1:0] row_in_1_r,
  output logic [IN_width-1:0] row_in_1_i,
  output logic [IN_width-1:0] row_in_2_r,
  output logic [IN_width-1:0] row_in_2_i,
  output logic [IN_width-1:0] row_in_3_r,
  output logic [IN_width-1:0] row_in_3_i,
  output logic [IN_width-1:0] row_in_4_r,
  output logic [IN_width-1:0] row_in_4_i,
  output logic                row_in_1_f,
  output logic                row_in_2_f,
  output logic                row_in_3_f,
  output logic                busy,
  output logic                frame_err
);

  localparam int unsigned SW      = 2 * IN_width;
  localparam int unsigned ENTRIES = 20;
  localparam int unsigned T_LAST  = ROW4_T0 + 4;
  localparam int unsigned TW      = $clog2(T_LAST + 1);
`ifdef QRD_FEED_PINGPONG_EN
  localparam int unsigned NBANK   = 2;
`else
  localparam int unsigned NBANK   = 1;
`endif
  localparam int unsigned AW      = $clog2(NBANK * ENTRIES);

  typedef enum logic [1:0] {LOAD, WAIT_RDY, PLAY} state_t;

  state_t        state;
  logic [4:0]    wr_idx;
  logic [TW-1:0] t;
  logic [TW-1:0] nt;
  logic          drive;
  logic          xfer;
  logic          at_end;
  logic          good_last;
  logic          bad_frame;
  logic [AW-1:0] waddr;
  int unsigned   tn;
  int unsigned   rb_off;
  int unsigned   wb_off;
  logic [SW-1:0] w1, w2, w3, w4;
  logic [SW-1:0] mem [NBANK*ENTRIES];

`ifdef QRD_FEED_PINGPONG_EN
  logic pl_bank;    // bank being (or next to be) played
  logic full_idle;  // the other bank holds a complete matrix
  logic wr_bank;
`endif

  // Handshake and frame-shape decode
  assign xfer      = s_valid & s_ready;
  assign at_end    = (wr_idx == 5'd19);
  assign good_last = xfer & s_last & at_end;
  assign bad_frame = xfer & (s_last ^ at_end);
  assign busy      = (state != LOAD);

`ifdef QRD_FEED_PINGPONG_EN
  assign s_ready = (state == LOAD) | ~full_idle;
`else
  assign s_ready = (state == LOAD);
`endif

  // Play-cycle sequencing: nt is the schedule slot the outputs will show next
  assign drive = ((state == WAIT_RDY) & qrd_in_ready) |
                 ((state == PLAY) & (t != TW'(T_LAST)));
  assign nt    = (state == WAIT_RDY) ? '0 : t + TW'(1);

  // Bank offsets and schedule lookup for the next output slot
  always_comb begin
    rb_off = 0;
    wb_off = 0;
`ifdef QRD_FEED_PINGPONG_EN
    // In LOAD the fill bank is the one that plays next; otherwise fill the idle one
    wr_bank = (state == LOAD) ? pl_bank : ~pl_bank;
    rb_off  = pl_bank ? ENTRIES : 0;
    wb_off  = wr_bank ? ENTRIES : 0;
`endif
    tn = 32'(nt);
    w1 = '0;
    w2 = '0;
    w3 = '0;
    w4 = '0;
    if (tn < 5)
      w1 = mem[AW'(rb_off + tn)];
    if (tn >= 1 && tn <= 5)
      w2 = mem[AW'(rb_off + 4 + tn)];
    if (tn >= ROW3_T0 && tn < ROW3_T0 + 5)
      w3 = mem[AW'(rb_off + 10 + tn - ROW3_T0)];
    if (tn >= ROW4_T0 && tn < ROW4_T0 + 5)
      w4 = mem[AW'(rb_off + 15 + tn - ROW4_T0)];
  end

  assign waddr = AW'(wb_off + 32'(wr_idx));

  // Sample buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (xfer)
      mem[waddr] <= {s_data_r, s_data_i};
  end

  // Registered row streams and frame markers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_in_1_r <= '0;
      row_in_1_i <= '0;
      row_in_2_r <= '0;
      row_in_2_i <= '0;
      row_in_3_r <= '0;
      row_in_3_i <= '0;
      row_in_4_r <= '0;
      row_in_4_i <= '0;
      row_in_1_f <= 1'b0;
      row_in_2_f <= 1'b0;
      row_in_3_f <= 1'b0;
    end else if (drive) begin
      row_in_1_r <= w1[SW-1:IN_width];
      row_in_1_i <= w1[IN_width-1:0];
      row_in_2_r <= w2[SW-1:IN_width];
      row_in_2_i <= w2[IN_width-1:0];
      row_in_3_r <= w3[SW-1:IN_width];
      row_in_3_i <= w3[IN_width-1:0];
      row_in_4_r <= w4[SW-1:IN_width];
      row_in_4_i <= w4[IN_width-1:0];
      row_in_1_f <= (nt == '0);
      row_in_2_f <= (nt == TW'(ROW2_F_T));
      row_in_3_f <= (nt == TW'(ROW3_F_T));
    end else begin
      row_in_1_r <= '0;
      row_in_1_i <= '0;
      row_in_2_r <= '0;
      row_in_2_i <= '0;
      row_in_3_r <= '0;
      row_in_3_i <= '0;
      row_in_4_r <= '0;
      row_in_4_i <= '0;
      row_in_1_f <= 1'b0;
      row_in_2_f <= 1'b0;
      row_in_3_f <= 1'b0;
    end
  end

  // Control FSM: load, wait for QRD, play the schedule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_idx    <= '0;
      t         <= '0;
      frame_err <= 1'b0;
`ifdef QRD_FEED_PINGPONG_EN
      pl_bank   <= 1'b0;
      full_idle <= 1'b0;
`endif
    end else begin
      frame_err <= bad_frame;
      // Any s_last or the 20th sample closes the frame, good or bad
      if (xfer)
        wr_idx <= (s_last | at_end) ? '0 : wr_idx + 5'd1;
`ifdef QRD_FEED_PINGPONG_EN
      if (state != LOAD && good_last)
        full_idle <= 1'b1;
`endif
      case (state)
        LOAD: begin
          if (good_last)
            state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (qrd_in_ready) begin
            state <= PLAY;
            t     <= '0;
          end
        end
        PLAY: begin
          if (t == TW'(T_LAST)) begin
`ifdef QRD_FEED_PINGPONG_EN
            // Swap banks; a matrix completing on this very edge counts as full
            pl_bank <= ~pl_bank;
            if (full_idle | good_last) begin
              state     <= WAIT_RDY;
              full_idle <= 1'b0;
            end else begin
              state <= LOAD;
            end
`else
            state <= LOAD;
`endif
          end else begin
            t <= t + TW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_qrd_row_feeder.sv
// Self-checking bench for qrd_row_feeder: random matrices and random valid
// gaps, checked cycle by cycle against the row schedule computed from the
// matrix contents.
module tb_qrd_row_feeder;

  localparam int W  = 14;
  localparam int SW = 2 * W;
`ifdef QRD_FEED_PINGPONG_EN
  localparam logic SR_BUSY = 1'b1;
`else
  localparam logic SR_BUSY = 1'b0;
`endif

  typedef logic [SW-1:0] mat_t [20];

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data_r;
  logic [W-1:0] s_data_i;
  logic         s_last;
  logic         qrd_in_ready;
  logic [W-1:0] row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i;
  logic [W-1:0] row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i;
  logic         row_in_1_f, row_in_2_f, row_in_3_f;
  logic         busy;
  logic         frame_err;

  int   checks;
  int   failures;
  logic ferr_due;
  int   exp_widx;

  qrd_row_feeder #(
    .IN_width(W),
    .ROW3_T0 (31),
    .ROW4_T0 (61),
    .ROW2_F_T(2),
    .ROW3_F_T(33)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data_r    (s_data_r),
    .s_data_i    (s_data_i),
    .s_last      (s_last),
    .qrd_in_ready(qrd_in_ready),
    .row_in_1_r  (row_in_1_r),
    .row_in_1_i  (row_in_1_i),
    .row_in_2_r  (row_in_2_r),
    .row_in_2_i  (row_in_2_i),
    .row_in_3_r  (row_in_3_r),
    .row_in_3_i  (row_in_3_i),
    .row_in_4_r  (row_in_4_r),
    .row_in_4_i  (row_in_4_i),
    .row_in_1_f  (row_in_1_f),
    .row_in_2_f  (row_in_2_f),
    .row_in_3_f  (row_in_3_f),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Row k (0..3) starts at play cycle 0, 1, 31, 61 and carries 5 samples
  function automatic int row_start(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 31;
      default: return 61;
    endcase
  endfunction

  function automatic logic [SW-1:0] exp_row(input mat_t m, input int k, input int tt);
    int c;
    c = tt - row_start(k);
    if (c >= 0 && c < 5) return m[5*k + c];
    return '0;
  endfunction

  function automatic mat_t seq_mat();
    mat_t m;
    for (int e = 0; e < 20; e++) m[e] = {W'(e), W'(-e)};
    return m;
  endfunction

  function automatic mat_t rand_mat(input bit extremes);
    mat_t m;
    for (int e = 0; e < 20; e++) m[e] = SW'($urandom);
    if (extremes) begin
      m[0]  = {14'h2000, 14'h2000};
      m[3]  = {14'h2000, 14'h1FFF};
      m[12] = {14'h1FFF, 14'h1FFF};
      m[19] = {14'h1FFF, 14'h2000};
    end
    return m;
  endfunction

  function automatic logic [127:0] all_rows();
    return 128'({row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i,
                 row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i});
  endfunction

  // Rows zero, markers low, frame_err low; busy and s_ready as given
  task automatic chk_quiet(input string tag, input logic busy_e, input logic sr_e);
    check({tag, "_rows"}, all_rows(), 128'(0));
    check({tag, "_flags"}, 128'({row_in_1_f, row_in_2_f, row_in_3_f, busy, frame_err, s_ready}),
          128'({3'b000, busy_e, 1'b0, sr_e}));
  endtask

  // Send the first n samples of m; s_last on index last_at (-1: never); pct = valid density
  task automatic load(input mat_t m, input int n, input int last_at, input int pct);
    int   i;
    logic v;
    i = 0;
    while (i < n) begin
      v        = ($urandom_range(99) < pct);
      s_valid  = v;
      s_data_r = v ? m[i][SW-1:W] : W'($urandom);
      s_data_i = v ? m[i][W-1:0]  : W'($urandom);
      s_last   = v && (i == last_at);
      @(negedge clk);
      check("s_ready_load", 128'(s_ready), 128'(1));
      check("frame_err", 128'(frame_err), 128'(ferr_due));
      ferr_due = 1'b0;
      if (v) begin
        if (s_last != (exp_widx == 19)) begin
          ferr_due = 1'b1;
          exp_widx = 0;
        end else if (s_last) begin
          exp_widx = 0;
        end else begin
          exp_widx++;
        end
        i++;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      s_valid = 1'b0;
      @(negedge clk);
      check("idle_ferr", 128'(frame_err), 128'(ferr_due));
      ferr_due = 1'b0;
      check("idle_busy", 128'({busy, s_ready}), 128'(2'b01));
      check("idle_rows", all_rows(), 128'(0));
      @(posedge clk); #1;
    end
  endtask

  // Hold qrd_in_ready low for 'hold' cycles, then play; optional reset at t == rst_at
  task automatic play(input mat_t m, input int hold, input int rst_at, input bit sr_chk);
    if (hold > 0) begin
      qrd_in_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        chk_quiet("hold", 1'b1, SR_BUSY);
      end
      @(posedge clk); #1;
    end
    qrd_in_ready = 1'b1;
    @(negedge clk);
    check("arm_rows", all_rows(), 128'(0));
    check("arm_busy", 128'({busy, row_in_1_f}), 128'(2'b10));
    for (int tt = 0; tt <= 65; tt++) begin
      @(negedge clk);
      check("row1", 128'({row_in_1_r, row_in_1_i}), 128'(exp_row(m, 0, tt)));
      check("row2", 128'({row_in_2_r, row_in_2_i}), 128'(exp_row(m, 1, tt)));
      check("row3", 128'({row_in_3_r, row_in_3_i}), 128'(exp_row(m, 2, tt)));
      check("row4", 128'({row_in_4_r, row_in_4_i}), 128'(exp_row(m, 3, tt)));
      check("play_flags", 128'({row_in_1_f, row_in_2_f, row_in_3_f, busy, frame_err}),
            128'({tt == 0, tt == 2, tt == 33, 1'b1, 1'b0}));
      if (sr_chk) check("s_ready_play", 128'(s_ready), 128'(SR_BUSY));
      if (tt == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("async_rst", 1'b0, 1'b1);
        ferr_due = 1'b0;
        exp_widx = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  task automatic tail(input logic busy_e);
    @(negedge clk);
    chk_quiet("tail", busy_e, 1'b1);
    @(posedge clk); #1;
  endtask

  mat_t ma, mb;

  initial begin
    checks       = 0;
    failures     = 0;
    ferr_due     = 1'b0;
    exp_widx     = 0;
    rst_n        = 1'b0;
    s_valid      = 1'b0;
    s_last       = 1'b0;
    s_data_r     = '0;
    s_data_i     = '0;
    qrd_in_ready = 1'b0;

    // Reset state
    #12;
    chk_quiet("reset", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Index-valued matrix, QRD already ready
    qrd_in_ready = 1'b1;
    ma = seq_mat();
    load(ma, 20, 19, 100);
    play(ma, 0, -1, 1'b1);
    tail(1'b0);

    // QRD not ready for 10 cycles after load
    ma = rand_mat(1'b0);
    load(ma, 20, 19, 100);
    play(ma, 10, -1, 1'b1);
    tail(1'b0);

    // Early s_last, then a correct matrix right behind it
    mb = rand_mat(1'b0);
    load(mb, 12, 11, 100);
    ma = rand_mat(1'b0);
    load(ma, 20, 19, 100);
    play(ma, 0, -1, 1'b1);
    tail(1'b0);

    // Missing s_last on the 20th sample: no play even with QRD ready
    qrd_in_ready = 1'b1;
    load(mb, 20, -1, 100);
    idle(4);

    // Random valid gaps with full-scale values
    for (int k = 0; k < 3; k++) begin
      ma = rand_mat(1'b1);
      load(ma, 20, 19, 50);
      play(ma, $urandom_range(3), -1, 1'b1);
      tail(1'b0);
    end

    // Reset at play cycle 40, then a fresh matrix plays from t = 0
    ma = rand_mat(1'b0);
    load(ma, 20, 19, 100);
    play(ma, 0, 40, 1'b1);
    ma = rand_mat(1'b1);
    load(ma, 20, 19, 70);
    play(ma, 0, -1, 1'b1);
    tail(1'b0);

`ifdef QRD_FEED_PINGPONG_EN
    // Back-to-back matrices: second loads while first plays
    ma = rand_mat(1'b0);
    mb = rand_mat(1'b1);
    load(ma, 20, 19, 100);
    fork
      load(mb, 20, 19, 100);
      play(ma, 0, -1, 1'b0);
    join
    play(mb, 0, -1, 1'b1);
    tail(1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
